// File: rtl/adc_event_buf.sv
// Multi-channel ADC event buffer: a free-running ring buffer that freezes an
// EVT_LEN-sample window around an L0 trigger and holds it for random-access readout.
module adc_event_buf #(
    parameter int DEPTH   = 256,
    parameter int EVT_LEN = 32,
    parameter int NCH     = 64,
    parameter int SW      = 12
) (
    input  logic                       adc_clk,
    input  logic                       rst,
    input  logic [NCH*SW-1:0]          adc_data_in,
    input  logic [7:0]                 trigger_latency,
    input  logic                       trig_l0,
    input  logic [$clog2(EVT_LEN)-1:0] read_addr,
    input  logic                       rd_done,
    output logic [NCH*SW-1:0]          adc_data_out,
    output logic                       event_ready,
    output logic                       busy
);

    localparam int         AW       = $clog2(DEPTH);
    localparam int         DW       = NCH * SW;
    localparam logic [7:0] LAST_IDX = 8'(EVT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        HOLD
    } state_t;

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] evt_start;
    logic [7:0]    remaining;
    logic          trig_d;
    logic          trig_edge;
    logic          wr_en;
    logic [AW-1:0] rd_idx;

    logic [DW-1:0] mem [DEPTH];

    assign trig_edge = trig_l0 & ~trig_d;
    assign wr_en     = (state != HOLD);
    assign rd_idx    = evt_start + AW'(read_addr);

    // Control FSM; remaining counts post-trigger writes still owed to the window.
    always_ff @(posedge adc_clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            evt_start   <= '0;
            remaining   <= '0;
            trig_d      <= 1'b0;
            event_ready <= 1'b0;
            busy        <= 1'b0;
        end else begin
            trig_d <= trig_l0;
            case (state)
                IDLE: begin
                    wr_ptr <= wr_ptr + AW'(1);
                    if (trig_edge) begin
                        evt_start <= wr_ptr - AW'(trigger_latency);
                        busy      <= 1'b1;
                        if (trigger_latency >= LAST_IDX) begin
                            state       <= HOLD;
                            event_ready <= 1'b1;
                        end else begin
                            state     <= CAPTURE;
                            remaining <= LAST_IDX - trigger_latency;
                        end
                    end
                end
                CAPTURE: begin
                    wr_ptr    <= wr_ptr + AW'(1);
                    remaining <= remaining - 8'd1;
                    if (remaining == 8'd1) begin
                        state       <= HOLD;
                        event_ready <= 1'b1;
                    end
                end
                HOLD: begin
                    if (rd_done) begin
                        state       <= IDLE;
                        event_ready <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    event_ready <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    // Sample RAM is deliberately not reset; only the write pointer is.
    always_ff @(posedge adc_clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr] <= adc_data_in;
        end
    end

    always_ff @(posedge adc_clk or posedge rst) begin
        if (rst) begin
            adc_data_out <= '0;
        end else begin
            adc_data_out <= mem[rd_idx];
        end
    end

endmodule

// File: tb/tb_adc_event_buf.sv
// Directed bench for adc_event_buf: ramp input, trigger/readout scenarios,
// wrap-around, ignored re-triggers and reset mid-capture.
module tb_adc_event_buf;

    localparam int NCH = 64;
    localparam int SW  = 12;
    localparam int DW  = NCH * SW;

    logic          adc_clk = 1'b0;
    logic          rst;
    logic [DW-1:0] adc_data_in;
    logic [7:0]    trigger_latency;
    logic          trig_l0;
    logic [4:0]    read_addr;
    logic          rd_done;
    logic [DW-1:0] adc_data_out;
    logic          event_ready;
    logic          busy;

    int edge_n;
    int vectors;
    int miscompares;

    adc_event_buf dut (
        .adc_clk        (adc_clk),
        .rst            (rst),
        .adc_data_in    (adc_data_in),
        .trigger_latency(trigger_latency),
        .trig_l0        (trig_l0),
        .read_addr      (read_addr),
        .rd_done        (rd_done),
        .adc_data_out   (adc_data_out),
        .event_ready    (event_ready),
        .busy           (busy)
    );

    always #5 adc_clk = ~adc_clk;

    // Ramp pattern: channel k of sample n carries (n + k) mod 4096.
    function automatic logic [DW-1:0] ramp(input int n);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < NCH; k++) r[k*SW +: SW] = SW'((n + k) % 4096);
        return r;
    endfunction

    task automatic applyStimulus(input logic trig, input logic done, input logic [4:0] ra);
        trig_l0     = trig;
        rd_done     = done;
        read_addr   = ra;
        adc_data_in = ramp(edge_n);
        @(posedge adc_clk);
        #1;
        edge_n++;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 5'd0);
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checkOutput(tag, {255'd0, obs}, {255'd0, exp});
    endtask

    task automatic checkWord(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        for (int i = 0; i < DW / 256; i++)
            checkOutput($sformatf("%s_w%0d", tag, i), obs[i*256 +: 256], exp[i*256 +: 256]);
    endtask

    initial begin
        int e;
        edge_n          = 0;
        vectors         = 0;
        miscompares     = 0;
        rst             = 1'b1;
        trig_l0         = 1'b0;
        rd_done         = 1'b0;
        read_addr       = 5'd0;
        trigger_latency = 8'd10;
        adc_data_in     = '0;

        repeat (3) @(posedge adc_clk);
        #1;
        checkBit("rst_busy", busy, 1'b0);
        checkBit("rst_ready", event_ready, 1'b0);
        checkWord("rst_data", adc_data_out, '0);
        rst    = 1'b0;
        edge_n = 0;

        // Ramp, L=10, trigger at sample 100: window is samples 90..121.
        idle(100);
        applyStimulus(1'b1, 1'b0, 5'd0);
        checkBit("A_busy_trig", busy, 1'b1);
        checkBit("A_ready_trig", event_ready, 1'b0);
        idle(20);
        checkBit("A_ready_120", event_ready, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0);
        checkBit("A_ready_121", event_ready, 1'b1);
        checkBit("A_busy_121", busy, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'd0);
        checkWord("A_rd0", adc_data_out, ramp(90));
        checkOutput("A_rd0_ch0", {244'd0, adc_data_out[11:0]}, 256'd90);
        checkOutput("A_rd0_ch63", {244'd0, adc_data_out[63*12 +: 12]}, 256'd153);
        applyStimulus(1'b0, 1'b0, 5'd17);
        checkWord("A_rd17", adc_data_out, ramp(107));
        applyStimulus(1'b0, 1'b0, 5'd31);
        checkWord("A_rd31", adc_data_out, ramp(121));
        // Trigger coincident with rd_done is lost; the still-high level must not retrigger.
        applyStimulus(1'b1, 1'b1, 5'd0);
        checkBit("A_busy_done", busy, 1'b0);
        checkBit("A_ready_done", event_ready, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd0);
        checkBit("A_no_retrig", busy, 1'b0);

        // L=31: trigger goes straight to HOLD and is the last sample of the window.
        trigger_latency = 8'd31;
        idle(40);
        e = edge_n;
        applyStimulus(1'b1, 1'b0, 5'd31);
        checkBit("B_busy", busy, 1'b1);
        checkBit("B_ready", event_ready, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'd31);
        checkWord("B_rd31", adc_data_out, ramp(e));
        applyStimulus(1'b0, 1'b0, 5'd0);
        checkWord("B_rd0", adc_data_out, ramp(e - 31));
        applyStimulus(1'b0, 1'b1, 5'd0);
        checkBit("B_busy_done", busy, 1'b0);

        // Extra trigger edges during CAPTURE and HOLD are dropped.
        trigger_latency = 8'd10;
        idle(15);
        e = edge_n;
        applyStimulus(1'b1, 1'b0, 5'd0);
        applyStimulus(1'b0, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd0);
        idle(18);
        checkBit("C_ready_early", event_ready, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0);
        checkBit("C_ready", event_ready, 1'b1);
        applyStimulus(1'b1, 1'b0, 5'd0);
        applyStimulus(1'b0, 1'b0, 5'd0);
        checkBit("C_hold_busy", busy, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'd0);
        checkWord("C_rd0", adc_data_out, ramp(e - 10));
        applyStimulus(1'b0, 1'b0, 5'd31);
        checkWord("C_rd31", adc_data_out, ramp(e + 21));
        applyStimulus(1'b0, 1'b1, 5'd0);
        checkBit("C_busy_done", busy, 1'b0);
        idle(12);
        e = edge_n;
        applyStimulus(1'b1, 1'b0, 5'd0);
        idle(21);
        checkBit("C2_ready", event_ready, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'd3);
        checkWord("C2_rd3", adc_data_out, ramp(e - 7));
        applyStimulus(1'b0, 1'b1, 5'd0);

        // trig_l0 held high for 20 cycles gives exactly one capture.
        idle(12);
        e = edge_n;
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 5'd0);
        checkBit("D_busy", busy, 1'b1);
        checkBit("D_ready_early", event_ready, 1'b0);
        idle(2);
        checkBit("D_ready", event_ready, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'd0);
        checkWord("D_rd0", adc_data_out, ramp(e - 10));
        applyStimulus(1'b0, 1'b1, 5'd0);
        idle(5);
        checkBit("D_idle_busy", busy, 1'b0);

        // Reset mid-CAPTURE clears outputs at once and restarts from wr_ptr=0.
        idle(12);
        applyStimulus(1'b1, 1'b0, 5'd0);
        idle(5);
        rst = 1'b1;
        #1;
        checkBit("E_rst_busy", busy, 1'b0);
        checkBit("E_rst_ready", event_ready, 1'b0);
        checkWord("E_rst_data", adc_data_out, '0);
        @(posedge adc_clk);
        #1;
        rst    = 1'b0;
        edge_n = 0;

        // Trigger at wr_ptr=5 with L=10: window 251..255,0..26 wraps through address 0.
        idle(261);
        applyStimulus(1'b1, 1'b0, 5'd0);
        checkOutput("F_evt_start", {248'd0, dut.evt_start}, 256'd251);
        idle(21);
        checkBit("F_ready", event_ready, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'd0);
        checkWord("F_rd0", adc_data_out, ramp(251));
        applyStimulus(1'b0, 1'b0, 5'd4);
        checkWord("F_rd4", adc_data_out, ramp(255));
        applyStimulus(1'b0, 1'b0, 5'd5);
        checkWord("F_rd5", adc_data_out, ramp(256));
        checkOutput("F_rd5_ch0", {244'd0, adc_data_out[11:0]}, 256'd256);
        applyStimulus(1'b0, 1'b0, 5'd31);
        checkWord("F_rd31", adc_data_out, ramp(282));
        applyStimulus(1'b0, 1'b1, 5'd0);
        checkBit("F_busy_done", busy, 1'b0);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adc_event_buf.md
ADC_EVENT_BUF -- requirements
Module: adc_event_buf

Interface
REQ-001: Parameters: DEPTH 256 (ring-buffer samples, power of 2); EVT_LEN 32 (samples per event); NCH 64 (channels); SW 12 (sample bits).
REQ-002: adc_clk  in  1  sole clock; one sample word per rising edge; one clock; reset is asynchronous and active-high.
REQ-003: rst  in  1  asynchronous, active-high reset.
REQ-004: adc_data_in  in  NCH*SW  parallel sample word; channel k at bits [12k+11:12k].
REQ-005: trigger_latency  in  8  pre-trigger depth L in samples; legal range 0..DEPTH-EVT_LEN; static while capturing.
REQ-006: trig_l0  in  1  L0 trigger level, synchronous to adc_clk; a rising edge starts a capture.
REQ-007: read_addr  in  5  sample index within the held event, 0..EVT_LEN-1.
REQ-008: rd_done  in  1  one-cycle pulse that releases the held event.
REQ-009: adc_data_out  out  NCH*SW  event sample at read_addr, same packing as adc_data_in.
REQ-010: event_ready  out  1  high while an event is held and readable.
REQ-011: busy  out  1  high in CAPTURE or HOLD; triggers are ignored while high.

Function
REQ-012: Storage is a DEPTH x (NCH*SW) RAM indexed by an 8-bit write pointer wr_ptr that wraps DEPTH-1 -> 0.
REQ-013: States are IDLE, CAPTURE and HOLD.
- In IDLE and CAPTURE, each edge writes mem[wr_ptr] <= adc_data_in and increments wr_ptr.
- In HOLD, writes and wr_ptr are frozen.
REQ-014: Trigger edge detection:
- trig_d is trig_l0 registered.
- A trigger is trig_l0=1 and trig_d=0, acted on only in IDLE.
- Trigger edges in CAPTURE or HOLD are dropped, not queued.
REQ-015: On a trigger at an edge that writes to wr_ptr=T:
- evt_start <= (T - L) mod DEPTH.
- The event is the EVT_LEN samples at addresses evt_start .. evt_start+EVT_LEN-1 (mod DEPTH).
REQ-016: Capture length:
- If L >= EVT_LEN-1, go directly IDLE -> HOLD.
- Otherwise go to CAPTURE and make exactly EVT_LEN-1-L further writes; the last write (to evt_start+EVT_LEN-1) moves to HOLD.
REQ-017: HOLD -> IDLE on rd_done=1; writing resumes on the next edge at the frozen wr_ptr.
- rd_done outside HOLD has no effect.
REQ-018: Read path:
- adc_data_out <= mem[(evt_start + read_addr) mod DEPTH], registered, one-cycle latency.
- The read runs in every state; data is meaningful only in HOLD.
REQ-019: Outputs:
- event_ready = (state==HOLD).
- busy = (state!=IDLE).
- Both are registered with the state.
REQ-020: Address arithmetic is modulo DEPTH; an event window straddling address 0 reads contiguously.
REQ-021: RAM contents are not reset. Samples not yet written since reset are undefined, and verification does not check them.
REQ-022: A trigger on the same edge that rd_done exits HOLD is ignored, because the state is not yet IDLE.

Reset
REQ-023: While rst=1:
- state=IDLE, wr_ptr=0, evt_start=0, trig_d=0.
- adc_data_out=0, event_ready=0, busy=0.
REQ-024: Reset asserted mid-CAPTURE or mid-HOLD abandons the event immediately; after release, operation resumes from IDLE with wr_ptr=0.

Verification
REQ-025: Scenario: ramp input (channel k = (n+k) mod 4096 at sample n), L=10, trigger at sample n=100.
- event_ready rises after sample 121 is written.
- read_addr=j returns channel k = 90+j+k.
REQ-026: Scenario: L=31 (EVT_LEN-1).
- busy rises and HOLD is entered on the edge after the trigger, with no CAPTURE.
- read_addr=31 returns the trigger sample.
REQ-027: Scenario: trigger at wr_ptr=5 with L=10.
- evt_start=251.
- read_addr 0..4 returns samples at addresses 251..255, and read_addr 5 returns address 0 (wrap-around).
REQ-028: Scenario: second trig_l0 edge during CAPTURE and during HOLD.
- The held event is unchanged.
- After rd_done, a new edge captures normally.
REQ-029: Scenario: trig_l0 held high for 20 cycles.
- Exactly one capture occurs.
REQ-030: Scenario: rst pulsed mid-CAPTURE.
- Outputs are 0 and busy=0 immediately.
- A subsequent trigger behaves as in REQ-025 relative to the new wr_ptr.
